demux16_collector: RTL and testbench
====================================

Name: demux16_collector

Overview:
- Serial-to-parallel collector: the write-side counterpart of the 16-to-1 bit-select mux.
- Accepts one bit per valid/ready beat and routes it, via a 1-to-16 demux, into the word position given by an internal index counter.
- Presents the completed 16-bit word on a valid/ready output handshake.
- Sits between a serial bit source (shift link or test driver) and word-wide consumers in the datapath labs.

Parameters:
- WIDTH, 16, word width; number of demux outputs.
- SEL_W, 4, index/select width; must equal clog2(WIDTH).
- LSB_FIRST, 1, 1 = first accepted bit goes to bit 0; 0 = first bit goes to bit WIDTH-1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_bit is valid this cycle.
- in_bit  in  1  serial data bit.
- in_ready  out  1  collector accepts a bit this cycle.
- sync_clr  in  1  abort the partial word and restart at index 0.
- out_valid  out  1  out_word holds a complete word.
- out_word  out  WIDTH  assembled word.
- out_ready  in  1  consumer takes the word this cycle.
- bit_idx  out  SEL_W  demux select for the next accepted bit (debug/visibility).

Behaviour:
- Reset: rst sampled high at a clk edge forces state=COLLECT, cnt=0, word register=0, out_valid=0, out_word=0, bit_idx=0 (LSB_FIRST=1) or WIDTH-1 (LSB_FIRST=0). rst has priority over all other inputs, including mid-word and in HOLD; a held word is lost.
- States:
  - COLLECT: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept condition: in_valid && in_ready.
- On accept in COLLECT:
  - word[pos] <= in_bit, where pos = cnt (LSB_FIRST=1) or WIDTH-1-cnt (LSB_FIRST=0).
  - All other word bits are unchanged; cnt <= cnt+1.
- bit_idx = pos, combinational from cnt.
- Word completion:
  - Accept while cnt==WIDTH-1 moves to HOLD on the next edge.
  - out_valid rises in the cycle after the 16th accepted bit; latency is 1 cycle.
  - cnt wraps to 0.
- HOLD:
  - out_word is stable and equals the word register.
  - in_valid is ignored (no accept, because in_ready=0).
  - sync_clr is ignored.
- Output handshake:
  - out_valid && out_ready moves to COLLECT on the next edge and clears the word register to 0.
  - The next bit can be accepted in the cycle after the handshake, so minimum word period is WIDTH+1 cycles.
- Backpressure: with out_ready=0, HOLD persists indefinitely and out_word does not change.
- sync_clr in COLLECT:
  - cnt <= 0 and word register <= 0.
  - A bit presented with in_valid in the same cycle is discarded (sync_clr wins).
  - No out_valid is produced for the aborted word.
- out_word in COLLECT shows the word register (partial word); consumers must qualify it with out_valid.
- No X propagation: every register has a defined reset and a defined next state.

Decomposition:
- Package demux16_pkg:
  - typedef enum logic {COLLECT, HOLD} coll_state_t.
  - localparams WIDTH_DEF=16 and SEL_W_DEF=4.
- Sub-module demux1to16, combinational:
  - Inputs: sel[SEL_W-1:0], en.
  - Output: one-hot we[WIDTH-1:0], with we[sel]=en and all other bits 0.
  - The collector uses we as per-bit write enables into the word register.
- Top level holds only the FSM, the counter and the register.

Test Plan:
- Reset, then send 16 bits of 16'h5555 LSB-first with in_valid held high and out_ready=1:
  - out_valid rises exactly 1 cycle after the 16th bit, with out_word=16'h5555.
  - in_ready is 0 for that one cycle, then returns to 1.
- Send 16'd1038 (16'h040E) bit-by-bit with random in_valid gaps:
  - out_word=16'h040E.
  - bit_idx steps 0..15 on accepts only.
- Complete 16'hB7BB with out_ready=0 for 5 cycles:
  - out_valid stays 1 and out_word stays 16'hB7BB.
  - in_valid pulses during HOLD are not accepted.
  - After out_ready=1, the next word 16'hBFFF collects correctly.
- After 7 bits, assert sync_clr together with in_valid:
  - bit_idx returns to 0.
  - A following full 16'd21 (16'h0015) yields exactly 16'h0015; no stale bits remain.
- Assert rst after 10 bits, and separately during HOLD:
  - Next cycle out_valid=0, bit_idx=0, out_word=0.
  - A fresh word collects correctly afterwards.
- LSB_FIRST=0 instance, send 1,0,1,1 followed by twelve 0s:
  - out_word=16'hB000.

Source files
------------

// File: rtl/demux16_pkg.sv
// Shared definitions for the serial-to-parallel collector.
// Contents:
//   coll_state_t - collector FSM states. COLLECT accepts bits; HOLD presents a finished word.
//   WIDTH_DEF    - default word width.
//   SEL_W_DEF    - default select/index width, equal to clog2(WIDTH_DEF).
package demux16_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } coll_state_t;

  localparam int WIDTH_DEF = 16;
  localparam int SEL_W_DEF = 4;

endpackage

// File: rtl/demux1to16.sv
// Combinational 1-to-WIDTH demultiplexer that produces one-hot write enables.
// Ports:
//   sel - index of the output to drive.
//   en  - value routed to we[sel].
//   we  - one-hot write-enable vector. we[sel] = en; every other bit is 0.
module demux1to16
  import demux16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [WIDTH-1:0] we
);

  always_comb begin
    we      = '0;
    we[sel] = en;
  end

endmodule

// File: rtl/demux16_collector.sv
// Serial-to-parallel collector. It accepts one bit per in_valid/in_ready beat
// and writes that bit into the word position selected by an internal index.
// A completed word is offered on an out_valid/out_ready handshake.
// Ports:
//   clk, rst   - clock; synchronous active-high reset.
//   in_valid   - in_bit is valid this cycle.
//   in_bit     - serial data bit.
//   in_ready   - high while collecting, low while a finished word is held.
//   sync_clr   - aborts the partial word and restarts at index 0. It is ignored in HOLD.
//   out_valid  - out_word holds a complete word.
//   out_word   - word register. While collecting it shows the partial word.
//   out_ready  - consumer takes the word this cycle.
//   bit_idx    - word position that the next accepted bit will be written to.
module demux16_collector
  import demux16_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int SEL_W     = SEL_W_DEF,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  input  logic             sync_clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_word,
  input  logic             out_ready,
  output logic [SEL_W-1:0] bit_idx
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

  coll_state_t      state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;

  logic [SEL_W-1:0] pos;
  logic             accept;
  logic [WIDTH-1:0] we;

  // For MSB-first collection, the count is mirrored so that the first bit lands in WIDTH-1.
  assign pos       = (LSB_FIRST != 0) ? cnt_q : (LAST - cnt_q);
  assign bit_idx   = pos;
  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == HOLD);
  assign out_word  = word_q;

  // sync_clr has priority over a bit presented in the same cycle, so that bit is dropped.
  assign accept = in_valid && in_ready && !sync_clr;

  demux1to16 #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_demux (
    .sel (pos),
    .en  (accept),
    .we  (we)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    unique case (state_q)
      COLLECT: begin
        if (sync_clr) begin
          cnt_d  = '0;
          word_d = '0;
        end else if (accept) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (we[i]) word_d[i] = in_bit;
          end
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        // Clear the word on handoff so that no stale bits leak into the next word.
        if (out_ready) begin
          state_d = COLLECT;
          word_d  = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: tb/tb_demux16_collector.sv
module tb_demux16_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_bit, sync_clr, out_ready;
  logic        in_ready, out_valid;
  logic [15:0] out_word;
  logic [3:0]  bit_idx;

  logic        m_in_valid, m_in_bit, m_sync_clr, m_out_ready;
  logic        m_in_ready, m_out_valid;
  logic [15:0] m_out_word;
  logic [3:0]  m_bit_idx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux16_collector #(.WIDTH(16), .SEL_W(4), .LSB_FIRST(1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .sync_clr  (sync_clr),
    .out_valid (out_valid),
    .out_word  (out_word),
    .out_ready (out_ready),
    .bit_idx   (bit_idx)
  );

  demux16_collector #(.WIDTH(16), .SEL_W(4), .LSB_FIRST(0)) u_msb (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (m_in_valid),
    .in_bit    (m_in_bit),
    .in_ready  (m_in_ready),
    .sync_clr  (m_sync_clr),
    .out_valid (m_out_valid),
    .out_word  (m_out_word),
    .out_ready (m_out_ready),
    .bit_idx   (m_bit_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed 16 bits LSB-first. Optionally insert random idle gaps; bit_idx must hold during a gap.
  task automatic send_word(input logic [15:0] w, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        int n;
        n = $urandom_range(0, 2);
        for (int g = 0; g < n; g++) begin
          in_valid = 1'b0;
          tick();
          chk("gap_idx", 32'(bit_idx), 32'(i));
        end
      end
      chk("idx_before_accept", 32'(bit_idx), 32'(i));
      chk("ready_collect", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_bit   = w[i];
      tick();
      in_valid = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] w;
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; sync_clr = 1'b0; out_ready = 1'b0;
    m_in_valid = 1'b0; m_in_bit = 1'b0; m_sync_clr = 1'b0; m_out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_word", 32'(out_word), 32'd0);
    chk("rst_bit_idx", 32'(bit_idx), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_msb_bit_idx", 32'(m_bit_idx), 32'd15);

    // 16'h5555 streamed back-to-back with in_valid high throughout.
    w = 16'h5555;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_bit = w[i];
      tick();
      if (i == 14) chk("5555_not_early", 32'(out_valid), 32'd0);
    end
    chk("5555_out_valid", 32'(out_valid), 32'd1);
    chk("5555_out_word", 32'(out_word), 32'h5555);
    chk("5555_in_ready_low", 32'(in_ready), 32'd0);
    // in_valid is still high. It must not be accepted during this HOLD cycle.
    tick();
    in_valid = 1'b0;
    chk("5555_in_ready_back", 32'(in_ready), 32'd1);
    chk("5555_out_valid_drop", 32'(out_valid), 32'd0);
    chk("5555_idx_after", 32'(bit_idx), 32'd0);
    chk("5555_word_cleared", 32'(out_word), 32'd0);

    // 16'h040E with random in_valid gaps.
    send_word(16'h040E, 1'b1);
    chk("040e_out_valid", 32'(out_valid), 32'd1);
    chk("040e_out_word", 32'(out_word), 32'h040E);
    tick();
    chk("040e_handoff", 32'(out_valid), 32'd0);

    // 16'hB7BB under 5 cycles of backpressure, with in_valid and sync_clr pulses during HOLD.
    out_ready = 1'b0;
    send_word(16'hB7BB, 1'b0);
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      in_bit   = 1'b1;
      sync_clr = (c == 2);
      tick();
      chk("b7bb_hold_valid", 32'(out_valid), 32'd1);
      chk("b7bb_hold_word", 32'(out_word), 32'hB7BB);
      chk("b7bb_hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; sync_clr = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("b7bb_release", 32'(out_valid), 32'd0);
    chk("b7bb_release_idx", 32'(bit_idx), 32'd0);
    send_word(16'hBFFF, 1'b0);
    chk("bfff_out_word", 32'(out_word), 32'hBFFF);
    tick();

    // sync_clr after 7 bits, with in_valid in the same cycle.
    in_valid = 1'b1; in_bit = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("clr_idx_before", 32'(bit_idx), 32'd7);
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0; in_valid = 1'b0;
    chk("clr_idx", 32'(bit_idx), 32'd0);
    chk("clr_word", 32'(out_word), 32'd0);
    chk("clr_no_valid", 32'(out_valid), 32'd0);
    send_word(16'h0015, 1'b0);
    chk("0015_out_word", 32'(out_word), 32'h0015);
    tick();

    // rst after 10 bits.
    in_valid = 1'b1; in_bit = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_idx", 32'(bit_idx), 32'd0);
    chk("rst_mid_word", 32'(out_word), 32'd0);

    // rst during HOLD drops the held word.
    out_ready = 1'b0;
    send_word(16'h1234, 1'b0);
    chk("1234_held", 32'(out_word), 32'h1234);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_hold_valid", 32'(out_valid), 32'd0);
    chk("rst_hold_idx", 32'(bit_idx), 32'd0);
    chk("rst_hold_word", 32'(out_word), 32'd0);
    chk("rst_hold_ready", 32'(in_ready), 32'd1);
    send_word(16'hA5C3, 1'b0);
    chk("a5c3_out_word", 32'(out_word), 32'hA5C3);
    chk("a5c3_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();

    // MSB-first instance: bits 1,0,1,1 followed by twelve 0s.
    w = 16'b1101;
    m_out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("msb_idx", 32'(m_bit_idx), 32'(15 - i));
      m_in_valid = 1'b1;
      m_in_bit   = (i < 4) ? w[i] : 1'b0;
      tick();
    end
    m_in_valid = 1'b0;
    chk("msb_out_valid", 32'(m_out_valid), 32'd1);
    chk("msb_out_word", 32'(m_out_word), 32'hB000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
